// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, data/tag widths, and the result-buffer entry.
package alu_pkg;

    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_TAG_W  = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD     = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB     = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND     = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR      = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR     = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR     = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_LAST_OP = 4'd5;

    // One queued ALU result with the status flags captured at push time.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [ALU_TAG_W-1:0]  rd;
        logic                  zero;
        logic                  neg;
        logic                  illegal;
    } alu_entry_t;

    // True for opcodes that the ALU implements.
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: legal = 1'b1;
            default:                                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : alu_pkg

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/illegal-opcode flag generator for a 32-bit ALU result.
// Shared between the result buffer and the branch unit.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] result,
    input  logic [ALU_OP_W-1:0]   alu_op,
    output logic                  zero_c,
    output logic                  neg_c,
    output logic                  illegal_c
);

    // The opcode table and the last-legal-opcode constant must agree.
    if (ALU_LAST_OP != ALU_NOR) begin : g_bad_op_map
        $error("alu_flag_gen: ALU_LAST_OP does not match the opcode table");
    end

    // Flags are pure functions of the result and opcode.
    always_comb begin
        zero_c    = (result == '0);
        neg_c     = result[ALU_DATA_W-1];
        illegal_c = !alu_op_legal(alu_op);
    end

endmodule : alu_flag_gen

// File: rtl/alu_result_buffer.sv
// Result buffer between the combinational ALU and the writeback port.
// Captures result, tag and derived flags in a DEPTH-entry FIFO with valid/ready on both sides.
// Entries become visible one cycle after push; there is no in-to-out bypass.
// Optional: define ALU_RESULT_BUFFER_STATS_EN to add stat_retired / stat_stall counters.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic [3:0]               in_alu_op,
    input  logic [TAG_W-1:0]         in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [TAG_W-1:0]         out_rd,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RESULT_BUFFER_STATS_EN
    ,
    output logic [31:0]              stat_retired,
    output logic [31:0]              stat_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointer wrap relies on a power-of-two depth; the entry tag field is sized by the package.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_result_buffer: DEPTH must be a power of two in 2..16");
    end
    if (TAG_W != ALU_TAG_W) begin : g_bad_tag_w
        $error("alu_result_buffer: TAG_W must equal alu_pkg::ALU_TAG_W");
    end

    alu_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_c;
    logic              pop_c;
    logic              zero_c;
    logic              neg_c;
    logic              illegal_c;
    alu_entry_t        in_entry_c;
    alu_entry_t        head_c;

    alu_flag_gen u_flag_gen (
        .result    (in_result),
        .alu_op    (in_alu_op),
        .zero_c    (zero_c),
        .neg_c     (neg_c),
        .illegal_c (illegal_c)
    );

    // Handshake status derived from registered occupancy only.
    always_comb begin
        in_ready  = (count != FULL_CNT);
        out_valid = (count != '0);
        push_c    = in_valid && in_ready;
        pop_c     = out_valid && out_ready;
    end

    // Assemble the entry to be written on push.
    always_comb begin
        in_entry_c         = '0;
        in_entry_c.result  = in_result;
        in_entry_c.rd      = in_rd;
        in_entry_c.zero    = zero_c;
        in_entry_c.neg     = neg_c;
        in_entry_c.illegal = illegal_c;
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (push_c) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // Entry storage is not reset; a push coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= in_entry_c;
        end
    end

    // Head entry drives the outputs only while the buffer holds data.
    always_comb begin
        head_c      = mem[rd_ptr];
        out_result  = '0;
        out_rd      = '0;
        out_zero    = 1'b0;
        out_neg     = 1'b0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_result  = head_c.result;
            out_rd      = head_c.rd;
            out_zero    = head_c.zero;
            out_neg     = head_c.neg;
            out_illegal = head_c.illegal;
        end
    end

`ifdef ALU_RESULT_BUFFER_STATS_EN
    // Retired-entry and upstream-stall counters, both wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_retired <= '0;
            stat_stall   <= '0;
        end else begin
            if (pop_c) begin
                stat_retired <= stat_retired + 32'd1;
            end
            if (in_valid && !in_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule : alu_result_buffer

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_alu_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_result;
    logic [3:0]        in_alu_op;
    logic [TAG_W-1:0]  in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_rd;
    logic              out_zero;
    logic              out_neg;
    logic              out_illegal;
    logic [2:0]        count;
`ifdef ALU_RESULT_BUFFER_STATS_EN
    logic [31:0]       stat_retired;
    logic [31:0]       stat_stall;
`endif

    alu_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_alu_op   (in_alu_op),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_illegal (out_illegal),
        .count       (count)
`ifdef ALU_RESULT_BUFFER_STATS_EN
        ,
        .stat_retired(stat_retired),
        .stat_stall  (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] rd;
        logic [3:0]       op;
    } exp_t;

    exp_t    q[$];
    longint  retired;
    longint  stall;
    int      checks;
    int      errors;

    // One clock of stimulus; the model follows the queue rules, then we return on the negedge.
    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] op,
                         input logic [TAG_W-1:0] rd, input logic ordy, input logic rst);
        bit   full;
        bit   empty;
        exp_t e;
        in_valid  = v;
        in_result = res;
        in_alu_op = op;
        in_rd     = rd;
        out_ready = ordy;
        rst_n     = ~rst;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            retired = 0;
            stall   = 0;
        end else begin
            if (v && full) stall++;
            if (ordy && !empty) begin
                void'(q.pop_front());
                retired++;
            end
            if (v && !full) begin
                e.res = res;
                e.rd  = rd;
                e.op  = op;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 4'd0, '0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'd0, '0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'd0, '0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
    endtask

    task automatic test_single_push();
        drive(1'b1, 32'h0, 4'd1, 5'd3, 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_zero, out_neg, out_illegal} !== 4'b1100)
            begin errors++; $display("FAIL single_flags got v/z/n/i=%b%b%b%b want 1100", out_valid, out_zero, out_neg, out_illegal); end
        checks++;
        if (out_rd !== 5'd3) begin errors++; $display("FAIL single_rd got %0d want 3", out_rd); end
        checks++;
        if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        drive(1'b0, 32'h0, 4'd0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL single_drain got count=%0d valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] vals [4];
        vals[0] = 32'h8000_0000; vals[1] = 32'd5; vals[2] = 32'd7; vals[3] = 32'd9;
        for (int i = 0; i < 4; i++) drive(1'b1, vals[i], 4'd0, 5'(i + 8), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0)
            begin errors++; $display("FAIL fill_full got count=%0d ready=%b want 4/0", count, in_ready); end
        drive(1'b1, 32'hAA, 4'd0, 5'd1, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL fill_ignore got count=%0d want 4", count); end
        checks++;
        if (out_neg !== 1'b1 || out_result !== 32'h8000_0000)
            begin errors++; $display("FAIL fill_head got %h neg=%b want 80000000 neg=1", out_result, out_neg); end
        // Full with a pop in the same cycle: the push must still be refused.
        drive(1'b1, 32'hBB, 4'd0, 5'd2, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1)
            begin errors++; $display("FAIL full_pop got count=%0d ready=%b want 3/1", count, in_ready); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_result !== vals[i] || out_rd !== 5'(i + 8))
                begin errors++; $display("FAIL fill_order%0d got %h rd=%0d want %h rd=%0d", i, out_result, out_rd, vals[i], i + 8); end
            drive(1'b0, 32'h0, 4'd0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0)
            begin errors++; $display("FAIL fill_empty got valid=%b res=%h want 0/0", out_valid, out_result); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] expect_seq [6];
        drive(1'b1, 32'h21, 4'd2, 5'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 4'd3, 5'd2, 1'b0, 1'b0);
        drive(1'b1, 32'h11, 4'd4, 5'd3, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd2 || out_result !== 32'h22)
            begin errors++; $display("FAIL simul_count got count=%0d head=%h want 2/22", count, out_result); end
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h30 + 32'(i), 4'd0, 5'(i), 1'b1, 1'b0);
        expect_seq[0] = 32'h30; expect_seq[1] = 32'h31; expect_seq[2] = 32'h32;
        checks++;
        if (count !== 3'd2 || out_result !== expect_seq[1])
            begin errors++; $display("FAIL simul_wrap got count=%0d head=%h want 2/%h", count, out_result, expect_seq[1]); end
        drive(1'b0, 32'h0, 4'd0, '0, 1'b1, 1'b0);
        checks++;
        if (out_result !== expect_seq[2]) begin errors++; $display("FAIL simul_order got %h want %h", out_result, expect_seq[2]); end
        drive(1'b0, 32'h0, 4'd0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h1234, 4'd7, 5'd9, 1'b0, 1'b0);
        checks++;
        if (out_illegal !== 1'b1 || out_zero !== 1'b0)
            begin errors++; $display("FAIL illegal got ill=%b zero=%b want 1/0", out_illegal, out_zero); end
        drive(1'b1, 32'h1, 4'd5, 5'd9, 1'b1, 1'b0);
        checks++;
        if (out_illegal !== 1'b0) begin errors++; $display("FAIL legal_nor got ill=%b want 0", out_illegal); end
        drive(1'b0, 32'h0, 4'd0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h50 + 32'(i), 4'd0, 5'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 4'd0, 5'd7, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 4'd0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rstmid got count=%0d valid=%b ready=%b want 0/0/1", count, out_valid, in_ready); end
`ifdef ALU_RESULT_BUFFER_STATS_EN
        checks++;
        if (stat_retired !== 32'd0) begin errors++; $display("FAIL rstmid_retired got %0d want 0", stat_retired); end
`endif
        drive(1'b1, 32'h77, 4'd0, 5'd4, 1'b0, 1'b0);
        checks++;
        if (out_result !== 32'h77 || count !== 3'd1)
            begin errors++; $display("FAIL rstmid_fresh got %h count=%0d want 77/1", out_result, count); end
        drive(1'b0, 32'h0, 4'd0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0]      res;
        logic [TAG_W-1:0] rd;
        logic [3:0]       op;
        logic             v;
        logic             ordy;
        logic             rst;
        int unsigned      mode;
        logic [46:0]      got;
        logic [46:0]      want;
        exp_t             h;
        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 3);
            res  = (mode == 0) ? 32'h0 : (mode == 1) ? (32'h8000_0000 | $urandom) : $urandom;
            op   = 4'($urandom_range(0, 15));
            rd   = TAG_W'($urandom_range(0, 31));
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            rst  = (i % 131 == 70);
            drive(v, res, op, rd, ordy, rst);
            want = '0;
            want[46:44] = 3'(q.size());
            want[43]    = (q.size() != DEPTH);
            want[42]    = (q.size() != 0);
            if (q.size() != 0) begin
                h = q[0];
                want[41:10] = h.res;
                want[9:5]   = h.rd;
                want[4]     = (h.res == 32'h0);
                want[3]     = ($signed(h.res) < 0);
                want[2]     = (h.op > 4'd5);
            end
            got = {count, in_ready, out_valid, out_result, out_rd, out_zero, out_neg, out_illegal, 2'b00};
            checks++;
            if (got !== want)
                begin errors++; $display("FAIL random_cycle%0d got %h want %h", i, got, want); end
        end
`ifdef ALU_RESULT_BUFFER_STATS_EN
        checks++;
        if (stat_retired !== 32'(retired) || stat_stall !== 32'(stall))
            begin errors++; $display("FAIL stats got %0d/%0d want %0d/%0d", stat_retired, stat_stall, retired, stall); end
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        retired   = 0;
        stall     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_alu_op = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_push();
        test_fill();
        test_simultaneous();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_result_buffer
